smult_arbiter: RTL

//   Shares one smult4bit (4x4 signed Baugh-Wooley array multiplier) among NREQ requesters.

---
 rtl/smult_arbiter_if.sv | 26 ++
 rtl/smult_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/smult_arbiter_if.sv
// Request/result bundle between the requesting datapath units, the shared
// 4x4 signed multiplier arbiter, and the consumer of the product.
interface smult_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]   req;
   logic [4*NREQ-1:0] a_in;
   logic [4*NREQ-1:0] b_in;
   logic [NREQ-1:0]   gnt;
   logic              busy;
   logic [7:0]        p_out;
   logic [IDW-1:0]    p_id;
   logic              p_valid;
   logic              p_ready;

   modport master (
      output req, a_in, b_in, p_ready,
      input  gnt, busy, p_out, p_id, p_valid
   );

   modport slave (
      input  req, a_in, b_in, p_ready,
      output gnt, busy, p_out, p_id, p_valid
   );
endinterface

// File: rtl/smult_arbiter.sv
// Round-robin arbiter sharing one 4x4 signed Baugh-Wooley multiplier among NREQ
// requesters; returns the registered product and requester ID over valid/ready.
module smult_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input logic           clk,
   input logic           rst_n,
   smult_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t            state_r, state_s;
   logic [NREQ-1:0]   gnt_r, gnt_s;
   logic              busy_r, busy_s;
   logic [7:0]        p_out_r, p_out_s;
   logic [IDW-1:0]    p_id_r, p_id_s;
   logic              p_valid_r, p_valid_s;
   logic [IDW-1:0]    id_r, id_s;
   logic [IDW-1:0]    ptr_r, ptr_s;
   logic [3:0]        a_r, a_s;
   logic [3:0]        b_r, b_s;
   logic [2*NREQ-1:0] dbl_req_s;
   logic              found_s;
   logic [IDW-1:0]    win_s;
   logic [3:0]        a_sel_s;
   logic [3:0]        b_sel_s;
   logic [7:0]        product_s;

   // Baugh-Wooley: cross terms with exactly one sign bit are inverted, and the
   // constant ones at bits 4 and 7 complete the two's-complement correction.
   function automatic logic [7:0] bw_mult(input logic [3:0] a, input logic [3:0] b);
      logic [7:0] acc;
      logic       pp;
      acc = 8'h90;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            pp  = (a[i] & b[j]) ^ ((i == 3) != (j == 3));
            acc = acc + ({7'd0, pp} << (i + j));
         end
      end
      return acc;
   endfunction

   function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NREQ) begin
         sum = sum - NREQ;
      end else begin
         sum = sum;
      end
      return IDW'(sum);
   endfunction

   assign product_s = bw_mult(a_r, b_r);
   assign dbl_req_s = {bus.req, bus.req} >> ptr_r;

   // Round-robin search starting at the pointer; also selects the winner's operands.
   always_comb begin
      found_s = 1'b0;
      win_s   = '0;
      a_sel_s = 4'd0;
      b_sel_s = 4'd0;
      for (int off = 0; off < NREQ; off++) begin
         if (!found_s && dbl_req_s[off]) begin
            found_s = 1'b1;
            win_s   = wrap_add(ptr_r, off);
         end else begin
            found_s = found_s;
         end
      end
      for (int k = 0; k < NREQ; k++) begin
         if (win_s == IDW'(k)) begin
            a_sel_s = bus.a_in[4*k +: 4];
            b_sel_s = bus.b_in[4*k +: 4];
         end else begin
            a_sel_s = a_sel_s;
         end
      end
   end

   // Next-state and next-output logic; grant and result both leave on registers.
   always_comb begin
      state_s   = state_r;
      gnt_s     = '0;
      busy_s    = busy_r;
      p_out_s   = p_out_r;
      p_id_s    = p_id_r;
      p_valid_s = p_valid_r;
      id_s      = id_r;
      ptr_s     = ptr_r;
      a_s       = a_r;
      b_s       = b_r;
      case (state_r)
         IDLE: begin
            if (found_s) begin
               a_s     = a_sel_s;
               b_s     = b_sel_s;
               gnt_s   = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
               id_s    = win_s;
               ptr_s   = wrap_add(win_s, 1);
               busy_s  = 1'b1;
               state_s = MULT;
            end else begin
               busy_s  = 1'b0;
            end
         end
         MULT: begin
            p_out_s   = product_s;
            p_id_s    = id_r;
            p_valid_s = 1'b1;
            busy_s    = 1'b1;
            state_s   = HOLD;
         end
         HOLD: begin
            if (bus.p_ready) begin
               p_valid_s = 1'b0;
               busy_s    = 1'b0;
               state_s   = IDLE;
            end else begin
               busy_s    = 1'b1;
            end
         end
         default: begin
            p_valid_s = 1'b0;
            busy_s    = 1'b0;
            state_s   = IDLE;
         end
      endcase
   end

   // State and output registers; reset discards any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         gnt_r     <= '0;
         busy_r    <= 1'b0;
         p_out_r   <= 8'd0;
         p_id_r    <= '0;
         p_valid_r <= 1'b0;
         id_r      <= '0;
         ptr_r     <= '0;
         a_r       <= 4'd0;
         b_r       <= 4'd0;
      end else begin
         state_r   <= state_s;
         gnt_r     <= gnt_s;
         busy_r    <= busy_s;
         p_out_r   <= p_out_s;
         p_id_r    <= p_id_s;
         p_valid_r <= p_valid_s;
         id_r      <= id_s;
         ptr_r     <= ptr_s;
         a_r       <= a_s;
         b_r       <= b_s;
      end
   end

   assign bus.gnt     = gnt_r;
   assign bus.busy    = busy_r;
   assign bus.p_out   = p_out_r;
   assign bus.p_id    = p_id_r;
   assign bus.p_valid = p_valid_r;
endmodule
